// File: rtl/updown_counter_mod.sv
// WIDTH-bit up/down counter with programmable terminal value, synchronous load,
// wrap or saturate boundary mode, terminal-count, wrap pulse and sticky over/underflow flags.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

  // High exactly in the cycle whose edge produces the wrap pulse.
  assign tc = ~rst & en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    // Set below overrides clear when both happen on the same edge.
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          count_d = SATURATE ? MaxVal : '0;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_d = SATURATE ? '0 : MaxVal;
          wrap_d  = 1'b1;
          unf_d   = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
